// File: rtl/mem_check_master.sv
// mem_check_master
//   Fill-then-verify memory tester on an Avalon-MM master port. One pass
//   writes the pattern P(i) = seed + i to num_words consecutive 32-bit
//   words starting at base_addr. It then reads each word back in order,
//   compares it with the pattern and counts the mismatches.
//
//   Ports
//     clk, reset_n        clock, synchronous active-low reset
//     start               one-cycle request; accepted only in IDLE
//     base_addr           byte base of the region (bits [1:0] ignored)
//     num_words           number of words to test (0 = empty pass)
//     seed                pattern seed
//     busy                high while a pass is in progress
//     done                one-cycle pulse at the end of a pass
//     pass                last pass had no mismatch (valid from done on)
//     err_count           saturating mismatch count
//     first_err_addr      byte address of the first mismatch
//     avm_*               Avalon-MM master; one outstanding read at most
module mem_check_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  nw_r;
  logic [31:0]       seed_r;
  logic [CNT_W-1:0]  idx;

  logic              last;
  logic              rd_done;
  logic [DATA_W-1:0] exp_data;

  assign last     = (idx == nw_r - CNT_W'(1));
  assign exp_data = DATA_W'(seed_r + 32'(idx));
  // Read data is consumed in RD_WAIT, or in RD_REQ when it comes back in
  // the very cycle the read is accepted; anywhere else it is ignored.
  assign rd_done  = avm_readdatavalid &&
                    ((state == RD_WAIT) || (state == RD_REQ && !avm_waitrequest));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      base_r         <= '0;
      nw_r           <= '0;
      seed_r         <= '0;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r         <= {base_addr[ADDR_W-1:2], 2'b00};
            nw_r           <= num_words;
            seed_r         <= seed;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            if (num_words == '0) begin
              state <= FIN;
            end else begin
              // First write goes out registered in the next cycle.
              state          <= WRITE;
              avm_write      <= 1'b1;
              avm_address    <= {base_addr[ADDR_W-1:2], 2'b00};
              avm_writedata  <= DATA_W'(seed);
              avm_byteenable <= 4'hF;
            end
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            if (last) begin
              idx         <= '0;
              avm_write   <= 1'b0;
              avm_read    <= 1'b1;
              avm_address <= base_r;
              state       <= RD_REQ;
            end else begin
              idx           <= idx + CNT_W'(1);
              avm_address   <= avm_address + ADDR_W'(4);
              avm_writedata <= avm_writedata + DATA_W'(1);
            end
          end
        end
        RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            if (!avm_readdatavalid) state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
        end
        FIN: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Compare and advance; overrides the RD_REQ/RD_WAIT defaults above.
      if (rd_done) begin
        if (avm_readdata != exp_data) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          // avm_address still holds the address of the word just read.
          if (err_count == '0) first_err_addr <= avm_address;
        end
        if (last) begin
          state <= FIN;
        end else begin
          idx         <= idx + CNT_W'(1);
          avm_address <= avm_address + ADDR_W'(4);
          avm_read    <= 1'b1;
          state       <= RD_REQ;
        end
      end
    end
  end

endmodule
